// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One shift-and-subtract step per clock; start/done handshake with
// results held from the done cycle until the next accepted start.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   // Working partial remainder. The remainder is always below the divisor,
   // so it fits in WIDTH bits between steps; the extra bit only exists
   // transiently in the shifted value fed to the trial subtract.
   logic [WIDTH-1:0] r_rem_work;
   logic [WIDTH-1:0] r_quo_work;
   logic [WIDTH-1:0] r_divisor;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_accept;
   logic             w_zero_div;
   logic             w_last;
   logic [WIDTH:0]   w_shift_r;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic [WIDTH-1:0] w_r_step;
   logic [WIDTH-1:0] w_q_step;

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_zero_div = (divisor == '0);
   assign w_last     = (r_cnt == LAST_STEP);

   // One restoring step: shift {R,Q} left, trial-subtract the divisor,
   // keep the difference and set the quotient bit only when no borrow.
   assign w_shift_r = {r_rem_work, r_quo_work[WIDTH-1]};
   assign w_trial   = w_shift_r - {1'b0, r_divisor};
   assign w_borrow  = w_trial[WIDTH];
   assign w_r_step  = w_borrow ? w_shift_r[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_q_step  = {r_quo_work[WIDTH-2:0], ~w_borrow};

   // Next-state logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_zero_div ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem_work  <= '0;
         r_quo_work  <= '0;
         r_divisor   <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && !w_zero_div) begin
                  r_rem_work <= '0;
                  r_quo_work <= dividend;
                  r_divisor  <= divisor;
                  r_cnt      <= '0;
               end else if (w_accept) begin
                  r_quotient  <= '1;
                  r_remainder <= dividend;
                  r_dbz       <= 1'b1;
               end
            end
            S_RUN: begin
               r_rem_work <= w_r_step;
               r_quo_work <= w_q_step;
               r_cnt      <= r_cnt + 1'b1;
               // The final step lands directly in the result registers so
               // they change exactly on entry to DONE.
               if (w_last) begin
                  r_quotient  <= w_q_step;
                  r_remainder <= w_r_step;
                  r_dbz       <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule
